// File: rtl/payload_streamer_if.sv
// Operand/result handshake between the payload streamer and the DUT bus-functional model.
// The master drives beats out and receives DUT results.
interface payload_streamer_if #(
    parameter int W         = 16,
    parameter int RES_WIDTH = 8
);
    logic                 op_valid;
    logic [W-1:0]         op_data;
    logic                 op_ready;
    logic                 res_valid;
    logic [RES_WIDTH-1:0] res;

    modport master (
        output op_valid, op_data,
        input  op_ready, res_valid, res
    );

    modport slave (
        input  op_valid, op_data,
        output op_ready, res_valid, res
    );
endinterface

// File: rtl/payload_streamer.sv
// Beat-buffer replay engine: software loads beats, then a run streams them to the DUT
// over valid/ready (one-shot or looping) while DUT results are counted and summed.
module payload_streamer #(
    parameter int CHANNELS   = 2,
    parameter int ITEM_WIDTH = 8,
    parameter int DEPTH      = 1000,
    parameter int CNT_W      = $clog2(DEPTH + 1),
    parameter int RES_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic                           wr_en_i,
    input  logic [CHANNELS*ITEM_WIDTH-1:0] wr_data_i,
    output logic                           wr_full_o,
    output logic [CNT_W-1:0]               wr_level_o,
    input  logic                           start_i,
    input  logic                           loop_i,
    input  logic [CNT_W-1:0]               len_i,
    input  logic                           abort_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           aborted_o,
    payload_streamer_if.master             bus,
    output logic [31:0]                    beat_cnt_o,
    output logic [31:0]                    pass_cnt_o,
    output logic [31:0]                    res_cnt_o,
    output logic [31:0]                    res_sum_o
);
    localparam int W = CHANNELS * ITEM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_mem [DEPTH];
    logic [CNT_W-1:0] r_level;
    logic             r_full;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_rptr;
    logic             r_loop;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic             r_op_valid;
    logic [W-1:0]     r_op_data;
    logic [31:0]      r_beat_cnt;
    logic [31:0]      r_pass_cnt;
    logic [31:0]      r_res_cnt;
    logic [31:0]      r_res_sum;

    logic             w_write;
    logic [CNT_W-1:0] w_level_after;
    logic [CNT_W-1:0] w_eff_len;
    logic [W-1:0]     w_first_data;
    logic             w_xfer;
    logic             w_last;
    logic [W-1:0]     w_next_data;

    // Write acceptance, effective run length and next-beat selection.
    always_comb begin
        w_write       = (r_state == S_IDLE) && wr_en_i && !r_full;
        w_level_after = r_level + (w_write ? CNT_W'(1) : CNT_W'(0));
        if ((len_i == CNT_W'(0)) || (len_i > w_level_after)) begin
            w_eff_len = w_level_after;
        end else begin
            w_eff_len = len_i;
        end
        // A write landing in slot 0 during start must be forwarded, the array is not yet updated.
        if (w_write && (r_level == CNT_W'(0))) begin
            w_first_data = wr_data_i;
        end else begin
            w_first_data = r_mem[0];
        end
        w_xfer = r_op_valid && bus.op_ready;
        w_last = (r_rptr == (r_len - CNT_W'(1)));
        if (w_last) begin
            w_next_data = r_mem[0];
        end else begin
            w_next_data = r_mem[r_rptr + CNT_W'(1)];
        end
    end

    // Beat storage; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            r_mem[r_level] <= wr_data_i;
        end
    end

    // Run control FSM with all registered outputs and counters.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= S_IDLE;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_len      <= '0;
            r_rptr     <= '0;
            r_loop     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_op_valid <= 1'b0;
            r_op_data  <= '0;
            r_beat_cnt <= 32'd0;
            r_pass_cnt <= 32'd0;
            r_res_cnt  <= 32'd0;
            r_res_sum  <= 32'd0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (bus.res_valid) begin
                r_res_cnt <= r_res_cnt + 32'd1;
                r_res_sum <= r_res_sum + 32'(bus.res);
            end
            case (r_state)
                S_IDLE: begin
                    r_level <= w_level_after;
                    r_full  <= (w_level_after == CNT_W'(DEPTH));
                    if (start_i) begin
                        r_loop     <= loop_i;
                        r_len      <= w_eff_len;
                        r_rptr     <= '0;
                        r_aborted  <= 1'b0;
                        r_beat_cnt <= 32'd0;
                        r_pass_cnt <= 32'd0;
                        r_res_cnt  <= 32'd0;
                        r_res_sum  <= 32'd0;
                        if (w_eff_len == CNT_W'(0)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state    <= S_RUN;
                            r_busy     <= 1'b1;
                            r_op_valid <= 1'b1;
                            r_op_data  <= w_first_data;
                        end
                    end
                end
                S_RUN: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                        if (w_last) begin
                            r_pass_cnt <= r_pass_cnt + 32'd1;
                        end
                    end
                    if (abort_i) begin
                        r_state    <= S_DONE;
                        r_busy     <= 1'b0;
                        r_op_valid <= 1'b0;
                        r_aborted  <= 1'b1;
                    end else if (w_xfer) begin
                        if (w_last && !r_loop) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_op_valid <= 1'b0;
                        end else begin
                            r_rptr    <= w_last ? CNT_W'(0) : (r_rptr + CNT_W'(1));
                            r_op_data <= w_next_data;
                        end
                    end
                end
                S_DONE: begin
                    r_level <= '0;
                    r_full  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_full_o    = r_full;
    assign wr_level_o   = r_level;
    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign aborted_o    = r_aborted;
    assign bus.op_valid = r_op_valid;
    assign bus.op_data  = r_op_data;
    assign beat_cnt_o   = r_beat_cnt;
    assign pass_cnt_o   = r_pass_cnt;
    assign res_cnt_o    = r_res_cnt;
    assign res_sum_o    = r_res_sum;
endmodule

// File: tb/tb_payload_streamer.sv
// Bench for payload_streamer: directed runs checked every cycle against a transaction-level
// model of the beat buffer, plus literal expectations at the key points of each scenario.
module tb_payload_streamer;
    localparam int DEPTH = 1000;
    localparam int CNT_W = 10;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             wr_en_i;
    logic [15:0]      wr_data_i;
    logic             wr_full_o;
    logic [CNT_W-1:0] wr_level_o;
    logic             start_i;
    logic             loop_i;
    logic [CNT_W-1:0] len_i;
    logic             abort_i;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;
    logic [31:0]      beat_cnt_o;
    logic [31:0]      pass_cnt_o;
    logic [31:0]      res_cnt_o;
    logic [31:0]      res_sum_o;

    payload_streamer_if #(.W(16), .RES_WIDTH(8)) bus ();

    payload_streamer dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .wr_full_o  (wr_full_o),
        .wr_level_o (wr_level_o),
        .start_i    (start_i),
        .loop_i     (loop_i),
        .len_i      (len_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .aborted_o  (aborted_o),
        .bus        (bus),
        .beat_cnt_o (beat_cnt_o),
        .pass_cnt_o (pass_cnt_o),
        .res_cnt_o  (res_cnt_o),
        .res_sum_o  (res_sum_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: buffer contents, run progress and result totals.
    logic [15:0] m_buf [DEPTH];
    int          m_level, m_eff, m_beats, m_done_ctr, m_res_cnt;
    bit          m_running, m_loop, m_aborted;
    logic [31:0] m_res_sum;

    task automatic model_reset();
        m_level = 0; m_eff = 0; m_beats = 0; m_done_ctr = 0; m_res_cnt = 0;
        m_running = 0; m_loop = 0; m_aborted = 0; m_res_sum = 32'd0;
    endtask

    task automatic model_compare();
        int exp_pass;
        exp_pass = (m_eff != 0) ? (m_beats / m_eff) : 0;
        chk("op_valid", 32'(bus.op_valid), 32'(m_running));
        chk("busy", 32'(busy_o), 32'(m_running));
        chk("done", 32'(done_o), 32'(m_done_ctr == 1));
        chk("aborted", 32'(aborted_o), 32'(m_aborted));
        chk("wr_level", 32'(wr_level_o), 32'(m_level));
        chk("wr_full", 32'(wr_full_o), 32'(m_level == DEPTH));
        chk("beat_cnt", beat_cnt_o, 32'(m_beats));
        chk("pass_cnt", pass_cnt_o, 32'(exp_pass));
        chk("res_cnt", res_cnt_o, 32'(m_res_cnt));
        chk("res_sum", res_sum_o, m_res_sum);
        if (m_running) begin
            chk("op_data", 32'(bus.op_data), 32'(m_buf[m_beats % m_eff]));
        end
    endtask

    task automatic model_step();
        bit idle;
        int lvl;
        idle = !m_running && (m_done_ctr != 2);
        lvl  = m_level;
        if (m_done_ctr == 2) lvl = 0;
        if (m_done_ctr > 0) m_done_ctr--;
        if (idle && wr_en_i && (lvl < DEPTH)) begin
            m_buf[lvl] = wr_data_i;
            lvl++;
        end
        if (bus.res_valid) begin
            m_res_cnt++;
            m_res_sum = m_res_sum + 32'(bus.res);
        end
        if (idle && start_i) begin
            m_eff     = ((len_i == 10'd0) || (int'(len_i) > lvl)) ? lvl : int'(len_i);
            m_loop    = loop_i;
            m_beats   = 0;
            m_res_cnt = 0;
            m_res_sum = 32'd0;
            m_aborted = 0;
            if (m_eff == 0) m_done_ctr = 2;
            else m_running = 1;
        end else if (m_running) begin
            if (bus.op_ready) m_beats++;
            if (abort_i) begin
                m_running  = 0;
                m_aborted  = 1;
                m_done_ctr = 2;
            end else if (bus.op_ready && !m_loop && (m_beats == m_eff)) begin
                m_running  = 0;
                m_done_ctr = 2;
            end
        end
        m_level = lvl;
    endtask

    // Per-cycle compare against the model, then advance it with this cycle's inputs.
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            model_reset();
        end else begin
            model_compare();
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [15:0] beat_ab(input int a, input int b);
        return {8'(b), 8'(a)};
    endfunction

    task automatic write_beat(input logic [15:0] d);
        wr_en_i   = 1'b1;
        wr_data_i = d;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic load_abcd();
        for (int i = 0; i < 4; i++) write_beat(beat_ab(2 * i + 1, 2 * i + 2));
    endtask

    task automatic start_run(input int len, input bit loop);
        start_i = 1'b1;
        len_i   = CNT_W'(len);
        loop_i  = loop;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        chk(name, 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        logic [15:0] last_data;
        int          n_xfer;
        bit          finished;

        reset_ni = 1'b0; wr_en_i = 1'b0; wr_data_i = 16'd0; start_i = 1'b0;
        loop_i = 1'b0; len_i = '0; abort_i = 1'b0;
        bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res = 8'd0;
        #12;
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset op_valid", 32'(bus.op_valid), 32'd0);
        chk("reset level", 32'(wr_level_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        tick();
        reset_ni = 1'b1;
        tick();

        // One-shot run, ready held high; a result arriving with start is dropped.
        load_abcd();
        bus.op_ready  = 1'b1;
        bus.res_valid = 1'b1; bus.res = 8'h33;
        start_run(0, 1'b0);
        bus.res_valid = 1'b0;
        chk("t1 first valid", 32'(bus.op_valid), 32'd1);
        chk("t1 first data", 32'(bus.op_data), 32'h0201);
        wait_done(20, "t1 done");
        chk("t1 beat_cnt", beat_cnt_o, 32'd4);
        chk("t1 pass_cnt", pass_cnt_o, 32'd1);
        chk("t1 wr_level", 32'(wr_level_o), 32'd0);
        chk("t1 res_cnt", res_cnt_o, 32'd0);

        // Ready pattern 1,0,0 repeating: beat (3,4) must hold through the stall.
        load_abcd();
        start_run(0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            bus.op_ready = ((k % 3) == 0);
            if (k == 2) chk("t2 stall data", 32'(bus.op_data), 32'h0403);
            tick();
        end
        chk("t2 beat_cnt", beat_cnt_o, 32'd4);
        chk("t2 busy", 32'(busy_o), 32'd0);

        // Loop over the first two of three beats, then abort.
        write_beat(beat_ab(8'h11, 8'h22));
        write_beat(beat_ab(8'h33, 8'h44));
        write_beat(beat_ab(8'h55, 8'h66));
        bus.op_ready = 1'b1;
        start_run(2, 1'b1);
        for (int k = 0; k < 10; k++) tick();
        bus.op_ready = 1'b0;
        abort_i = 1'b1;
        chk("t3 beat_cnt", beat_cnt_o, 32'd10);
        chk("t3 pass_cnt", pass_cnt_o, 32'd5);
        tick();
        abort_i = 1'b0;
        chk("t3 aborted", 32'(aborted_o), 32'd1);
        wait_done(5, "t3 done");

        // Empty buffer: no beats, done two cycles after start, results still summed.
        start_run(0, 1'b0);
        chk("t5 done early", 32'(done_o), 32'd0);
        bus.res_valid = 1'b1; bus.res = 8'h10;
        tick();
        chk("t5 done", 32'(done_o), 32'd1);
        bus.res = 8'hF0;
        tick();
        bus.res = 8'hFF;
        tick();
        bus.res_valid = 1'b0;
        tick();
        chk("t5 res_cnt", res_cnt_o, 32'd3);
        chk("t5 res_sum", res_sum_o, 32'h1FF);

        // Overfill: last write ignored, replay ends on beat DEPTH-1.
        for (int i = 0; i <= DEPTH; i++) write_beat(16'(i));
        chk("t4 full", 32'(wr_full_o), 32'd1);
        chk("t4 level", 32'(wr_level_o), 32'(DEPTH));
        bus.op_ready = 1'b1;
        start_run(0, 1'b0);
        n_xfer = 0; last_data = 16'd0; finished = 1'b0;
        for (int k = 0; k < DEPTH + 20 && !finished; k++) begin
            @(negedge clk_i);
            if (bus.op_valid && bus.op_ready) begin
                n_xfer++;
                last_data = bus.op_data;
            end
            if (done_o) finished = 1'b1;
        end
        chk("t4 finished", 32'(finished), 32'd1);
        chk("t4 xfers", 32'(n_xfer), 32'(DEPTH));
        chk("t4 last beat", 32'(last_data), 32'(DEPTH - 1));
        tick();

        // Reset mid-run clears everything at once, then a fresh run works.
        load_abcd();
        start_run(0, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        reset_ni = 1'b0;
        #1;
        chk("t6 op_valid", 32'(bus.op_valid), 32'd0);
        chk("t6 busy", 32'(busy_o), 32'd0);
        chk("t6 beat_cnt", beat_cnt_o, 32'd0);
        chk("t6 pass_cnt", pass_cnt_o, 32'd0);
        chk("t6 level", 32'(wr_level_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6 no done", 32'(done_o), 32'd0);
        end
        reset_ni = 1'b1;
        tick();
        load_abcd();
        start_run(0, 1'b0);
        wait_done(20, "t6 done");
        chk("t6 rerun beat_cnt", beat_cnt_o, 32'd4);
        chk("t6 rerun pass_cnt", pass_cnt_o, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
